// File: rtl/ram_client_pkg.sv
// Shared definitions for the ram_sp_nc request-side client.
// Provides the strobe-width helper and a request record built on the
// default widths (10-bit address, 64-bit data).
package ram_client_pkg;

    localparam int unsigned DEF_ADDR_BITS = 10;
    localparam int unsigned DEF_DATA_BITS = 64;

    // One write strobe per data byte.
    function automatic int unsigned strb_bits(input int unsigned data_bits);
        return data_bits / 8;
    endfunction

    localparam int unsigned DEF_STRB_BITS = strb_bits(DEF_DATA_BITS);

    typedef struct packed {
        logic [DEF_STRB_BITS-1:0] we;
        logic [DEF_ADDR_BITS-1:0] addr;
        logic [DEF_DATA_BITS-1:0] data;
    } ram_req_t;

endpackage

// File: rtl/ram_client_resp_fifo.sv
// Synchronous response FIFO for ram_sp_nc_client.
// Ports:
//   clk, rstn_i        clock, asynchronous active-low reset
//   push_i, push_data_i write side (caller guarantees no overflow)
//   pop_i, pop_data_o   read side; pop_data_o reads 0 while empty
//   count_o, empty_o    occupancy
// DEPTH need not be a power of two; pointers wrap by compare-and-clear.
module ram_client_resp_fifo
    import ram_client_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is unreset; the empty gate below keeps stale/X words off the output.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        empty_o    = (count_q == '0);
        count_o    = count_q;
        pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/ram_sp_nc_client.sv
// Request-side master for one ram_sp_nc port.
// Ports:
//   clk, rstn_i                         clock shared with the RAM, async active-low reset
//   req_valid/req_ready/req_we/req_addr/req_data
//                                       request stream; req_we==0 is a read
//   resp_valid/resp_ready/resp_data     read data stream, in request order
//   ram_en/ram_we/ram_addr/ram_wdata    drive of RAM a_en/a_we/a_addr/a_data_in
//   ram_rdata                           RAM a_data_out (one-cycle read latency)
// Requests reach the RAM combinationally in their accept cycle. A credit of
// FIFO occupancy plus the one read in flight guarantees every issued read has
// a FIFO slot waiting for it.
module ram_sp_nc_client
    import ram_client_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned DATA_BITS  = 64,
    parameter int unsigned RESP_DEPTH = 4,
    localparam int unsigned STRB_BITS = strb_bits(DATA_BITS)
) (
    input  logic                 clk,
    input  logic                 rstn_i,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [STRB_BITS-1:0] req_we,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_data,
    output logic                 ram_en,
    output logic [STRB_BITS-1:0] ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_wdata,
    input  logic [DATA_BITS-1:0] ram_rdata
);

    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(RESP_DEPTH);

    logic          rd_inflight_q, rd_inflight_d;
    logic          accept;
    logic          fifo_empty;
    logic          resp_pop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;

    always_comb begin
        credit_used   = {1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight_q};
        // rstn_i term holds req_ready low throughout reset, not just after it.
        req_ready     = rstn_i && (credit_used < DEPTH_W);
        accept        = req_valid && req_ready;
        ram_en        = accept;
        ram_we        = accept ? req_we : '0;
        ram_addr      = req_addr;
        ram_wdata     = req_data;
        rd_inflight_d = accept && (req_we == '0);
        resp_valid    = !fifo_empty;
        resp_pop      = resp_valid && resp_ready;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_inflight_q <= 1'b0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
        end
    end

    // ram_rdata is only captured while a read is in flight; otherwise the
    // unreset RAM output register may be X.
    ram_client_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_resp_fifo (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .push_i      (rd_inflight_q),
        .push_data_i (ram_rdata),
        .pop_i       (resp_pop),
        .pop_data_o  (resp_data),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

endmodule
